// File: rtl/microtile_pkg.sv
// Shared types and constants for the microtile pad scheduler.
package microtile_pkg;

  localparam int unsigned TILE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/microtile_rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
module microtile_rr_arbiter
  import microtile_pkg::*;
#(
  parameter int unsigned N_TILES = 4,
  parameter int unsigned SEL_W   = $clog2(N_TILES)
) (
  input  logic [N_TILES-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               valid
);

  logic [SEL_W-1:0] cand;

  // Scan last+1 .. last+N (mod N); the last tile itself is checked last for fairness
  always_comb begin
    idx   = last;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N_TILES; i++) begin
      cand = SEL_W'((32'(last) + i) % N_TILES);
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/microtile_pad_scheduler.sv
// Time-shares one 8-bit pad pair between N combinational microtiles with
// round-robin grant, bounded dwell and settle/drain guard cycles.
module microtile_pad_scheduler
  import microtile_pkg::*;
#(
  parameter int unsigned N_TILES    = 4,
  parameter int unsigned DWELL      = 64,
  parameter int unsigned SETTLE_CYC = 2,
  localparam int unsigned SEL_W     = $clog2(N_TILES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_TILES-1:0]        req,
  input  logic [N_TILES-1:0]        rel,
  input  logic [TILE_W-1:0]         pad_ui,
  input  logic [TILE_W*N_TILES-1:0] tile_uo,
  output logic [TILE_W*N_TILES-1:0] tile_ui,
  output logic [TILE_W-1:0]         pad_uo,
  output logic [N_TILES-1:0]        grant,
  output logic [SEL_W-1:0]          sel,
  output logic                      busy,
  output logic                      timeout
);

  localparam int unsigned DW_W = $clog2(DWELL + 1);
  localparam int unsigned ST_W = $clog2(SETTLE_CYC + 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [N_TILES-1:0]  grant_q, grant_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [ST_W-1:0]     settle_q, settle_d;
  logic [TILE_W-1:0]   pad_q, pad_d;
  logic                tmo_q, tmo_d;
  logic                busy_q, busy_d;

  logic [SEL_W-1:0]    arb_idx;
  logic                arb_valid;
  logic                rel_sel, req_sel, expire;

  microtile_rr_arbiter #(
    .N_TILES (N_TILES),
    .SEL_W   (SEL_W)
  ) u_arb (
    .req   (req),
    .last  (sel_q),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign rel_sel = rel[sel_q];
  assign req_sel = req[sel_q];
  assign expire  = (dwell_q == DW_W'(DWELL - 1));

  // Next-state and next register values; only the granted tile's rel/req matter
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    dwell_d  = dwell_q;
    settle_d = settle_q;
    pad_d    = pad_q;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d  = SETTLE;
          sel_d    = arb_idx;
          grant_d  = N_TILES'(1) << arb_idx;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (settle_q == ST_W'(SETTLE_CYC - 1)) begin
          state_d  = ACTIVE;
          settle_d = '0;
          dwell_d  = '0;
        end else begin
          settle_d = settle_q + ST_W'(1);
        end
      end
      ACTIVE: begin
        pad_d   = tile_uo[TILE_W*32'(sel_q) +: TILE_W];
        dwell_d = dwell_q + DW_W'(1);
        if (rel_sel || !req_sel || expire) begin
          state_d = DRAIN;
          grant_d = '0;
          dwell_d = '0;
          tmo_d   = expire && !rel_sel && req_sel;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops everything without a drain cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= SEL_W'(N_TILES - 1);
      grant_q  <= '0;
      dwell_q  <= '0;
      settle_q <= '0;
      pad_q    <= '0;
      tmo_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      dwell_q  <= dwell_d;
      settle_q <= settle_d;
      pad_q    <= pad_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
    end
  end

  // Pad input reaches only the granted tile; all other slices held at zero
  always_comb begin
    tile_ui = '0;
    for (int unsigned i = 0; i < N_TILES; i++) begin
      if (grant_q[i]) tile_ui[TILE_W*i +: TILE_W] = pad_ui;
    end
  end

  assign pad_uo  = pad_q;
  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = tmo_q;

endmodule

// File: tb/tb_microtile_pad_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// tenure-based reference model (owner + cycles-since-grant).
module tb_microtile_pad_scheduler;

  localparam int N = 4;
  localparam int D = 8;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, rel;
  logic [7:0]     pad_ui;
  logic [8*N-1:0] tile_uo, tile_ui;
  logic [7:0]     pad_uo;
  logic [N-1:0]   grant;
  logic [1:0]     sel;
  logic           busy, timeout;

  always #5 clk = ~clk;

  microtile_pad_scheduler #(
    .N_TILES    (N),
    .DWELL      (D),
    .SETTLE_CYC (S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .pad_ui  (pad_ui),
    .tile_uo (tile_uo),
    .tile_ui (tile_ui),
    .pad_uo  (pad_uo),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  // Behaviour of each microtile: tile 2 inverts, others invert and tag the high nibble
  function automatic logic [7:0] tile_fn(int i, logic [7:0] x);
    return ~x ^ 8'(((i ^ 2) & 15) << 4);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_tile
    assign tile_uo[8*g +: 8] = tile_fn(g, tile_ui[8*g +: 8]);
  end

  // Reference model state
  int         owner, age, last, cyc;
  bit         draining, tmo;
  logic [7:0] pad_m;
  int         n_vec, n_err;
  int         order[$];
  int         ntmo;
  logic [N-1:0] pg;

  task automatic model_reset();
    owner = -1; age = 0; last = N - 1; draining = 0; tmo = 0; pad_m = 8'h00;
  endtask

  // One clock edge of the model, using the inputs present at the edge
  task automatic model_edge();
    bit t_n;
    bit r, q, e;
    int k;
    t_n = 0;
    if (draining) begin
      draining = 0;
      owner = -1;
    end else if (owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        if (owner < 0 && req[(last + i) % N]) begin
          owner = (last + i) % N;
          last = owner;
          age = 0;
        end
      end
    end else if (age < S) begin
      age++;
    end else begin
      k = age - S;
      pad_m = tile_fn(owner, pad_ui);
      r = rel[owner];
      q = req[owner];
      e = (k == D - 1);
      if (r || !q || e) begin
        draining = 1;
        t_n = e && !r && q;
      end
      age++;
    end
    tmo = t_n;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0]   g;
    logic [8*N-1:0] tu;
    g  = (owner >= 0 && !draining) ? (N'(1) << owner) : '0;
    tu = '0;
    for (int i = 0; i < N; i++) if (g[i]) tu[8*i +: 8] = pad_ui;
    chk("grant",   32'(grant),   32'(g));
    chk("tile_ui", tile_ui,      tu);
    chk("sel",     32'(sel),     32'(last));
    chk("busy",    32'(busy),    32'(owner >= 0));
    chk("timeout", 32'(timeout), 32'(tmo));
    chk("pad_uo",  32'(pad_uo),  32'(pad_m));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance until the model says the current cycle is ACTIVE cycle k (bounded)
  task automatic wait_active(int k, string tag);
    int b;
    b = 0;
    while (!(owner >= 0 && !draining && age >= S && age - S == k) && b < 100) begin
      step();
      b++;
    end
    chk(tag, 32'(b < 100), 32'd1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; ntmo = 0; pg = '0;
    rst = 1'b1; req = '0; rel = '0; pad_ui = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    chk("rst_sel", 32'(sel), 32'd3);
    @(negedge clk);
    rst = 1'b0;

    // Single requester, tile 2 inverts
    req = 4'b0100; pad_ui = 8'hA5;
    step();
    chk("s1_grant", 32'(grant), 32'h4);
    run(S);
    step();
    chk("s1_pad", 32'(pad_uo), 32'h5A);
    chk("s1_tile_ui", tile_ui, 32'h00A5_0000);
    run(3);
    req = '0;
    run(3);

    // All request, no release: strict rotation with one timeout per tenure
    do_reset();
    req = 4'b1111;
    repeat (5 * (S + D + 2)) begin
      step();
      if (grant != '0 && pg == '0) order.push_back(int'(sel));
      if (timeout) ntmo++;
      pg = grant;
    end
    chk("rr_count", 32'(order.size()), 32'd5);
    chk("rr_tmo", 32'(ntmo), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) chk("rr_order", 32'(order[i]), 32'(i % N));
    end

    // Early release at ACTIVE cycle 5
    req = '0;
    do_reset();
    req = 4'b0010;
    wait_active(5, "wait_rel");
    rel = 4'b0010;
    step();
    chk("rel_grant", 32'(grant), 32'h0);
    chk("rel_tmo", 32'(timeout), 32'h0);
    chk("rel_busy", 32'(busy), 32'h1);
    rel = '0; req = '0;
    run(2);

    // Tile 3 drops request while tile 0 waits: wrap 3 -> 0
    req = 4'b1000; pad_ui = 8'h69;
    wait_active(2, "wait_r3");
    req = 4'b0001;
    run(3);
    chk("wrap_grant", 32'(grant), 32'h1);
    chk("wrap_sel", 32'(sel), 32'h0);

    // Async reset mid-ACTIVE
    wait_active(3, "wait_rst");
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_tile_ui", tile_ui, 32'h0);
    chk("arst_pad", 32'(pad_uo), 32'h0);
    chk("arst_sel", 32'(sel), 32'd3);
    chk("arst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Release coincides with dwell expiry: no timeout pulse
    req = 4'b0001; pad_ui = 8'h3C;
    wait_active(D - 1, "wait_exp");
    rel = 4'b0001;
    step();
    chk("exp_tmo", 32'(timeout), 32'h0);
    chk("exp_grant", 32'(grant), 32'h0);
    chk("exp_busy", 32'(busy), 32'h1);
    rel = '0; req = '0;
    run(2);

    // Randomized traffic
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      rel = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      pad_ui = 8'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
